// File: rtl/parallel_to_serial_dac.sv
// Serialises 16-bit processed samples MSB-first onto the codec DAC line, framed by an
// externally generated lrclk, with a one-word holding register and deterministic underrun handling.
module parallel_to_serial_dac #(
  parameter int WIDTH         = 16,
  parameter bit DUAL_CHANNEL  = 1'b1,
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic             bclk,
  input  logic             reset_n,
  input  logic             lrclk,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_data,
  output logic             underrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT_L = 2'd1;
  localparam logic [1:0] SHIFT_R = 2'd2;

  logic             lrclk_d1_r;
  logic             lrclk_d2_r;
  logic [WIDTH-1:0] hold_r;
  logic             hold_full_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] last_sample_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [1:0]       state_r;
  logic             out_data_r;
  logic             underrun_r;
  logic             underran_r;

  logic             start_l_s;
  logic             start_r_s;
  logic             accept_s;
  logic [WIDTH-1:0] load_l_s;
  logic [WIDTH-1:0] load_r_s;
  logic [WIDTH-1:0] shift_next_s;

  assign start_l_s = lrclk_d2_r & ~lrclk_d1_r;
  assign start_r_s = ~lrclk_d2_r & lrclk_d1_r;
  assign accept_s  = in_valid & ~hold_full_r;

  assign in_ready = ~hold_full_r;
  assign out_data = out_data_r;
  assign underrun = underrun_r;
  assign busy     = (state_r != IDLE);

  // Select the word each slot type loads; a zero-mode underrun keeps the right slot silent too.
  always_comb begin
    load_l_s     = {WIDTH{1'b0}};
    load_r_s     = {WIDTH{1'b0}};
    shift_next_s = shift_r << 1'b1;
    if (hold_full_r) begin
      load_l_s = hold_r;
    end else if (UNDERRUN_ZERO) begin
      load_l_s = {WIDTH{1'b0}};
    end else begin
      load_l_s = last_sample_r;
    end
    if (DUAL_CHANNEL && !(UNDERRUN_ZERO && underran_r)) begin
      load_r_s = last_sample_r;
    end else begin
      load_r_s = {WIDTH{1'b0}};
    end
  end

  // Two-stage lrclk delay line feeding the slot-start edge detect.
  always_ff @(negedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      lrclk_d1_r <= 1'b0;
      lrclk_d2_r <= 1'b0;
    end else begin
      lrclk_d1_r <= lrclk;
      lrclk_d2_r <= lrclk_d1_r;
    end
  end

  // Holding register: drains at a left-slot start, otherwise accepts when empty.
  always_ff @(negedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      hold_r      <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
    end else if (start_l_s && hold_full_r) begin
      hold_full_r <= 1'b0;
    end else if (accept_s) begin
      hold_r      <= in_data;
      hold_full_r <= 1'b1;
    end
  end

  // Slot FSM and shifter; a start pulse always wins, so a short lrclk phase restarts at the MSB.
  always_ff @(negedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r       <= {WIDTH{1'b0}};
      last_sample_r <= {WIDTH{1'b0}};
      bit_cnt_r     <= {CW{1'b0}};
      state_r       <= IDLE;
      out_data_r    <= 1'b0;
      underrun_r    <= 1'b0;
      underran_r    <= 1'b0;
    end else if (start_l_s) begin
      shift_r    <= load_l_s;
      out_data_r <= load_l_s[WIDTH-1];
      bit_cnt_r  <= CW'(WIDTH-1);
      state_r    <= SHIFT_L;
      underrun_r <= ~hold_full_r;
      underran_r <= ~hold_full_r;
      if (hold_full_r) begin
        last_sample_r <= hold_r;
      end
    end else if (start_r_s) begin
      shift_r    <= load_r_s;
      out_data_r <= load_r_s[WIDTH-1];
      bit_cnt_r  <= CW'(WIDTH-1);
      state_r    <= SHIFT_R;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      case (state_r)
        SHIFT_L, SHIFT_R: begin
          if (bit_cnt_r != {CW{1'b0}}) begin
            shift_r    <= shift_next_s;
            out_data_r <= shift_next_s[WIDTH-1];
            bit_cnt_r  <= bit_cnt_r - CW'(1);
          end else begin
            out_data_r <= 1'b0;
            state_r    <= IDLE;
          end
        end
        IDLE: begin
          out_data_r <= 1'b0;
        end
        default: begin
          out_data_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_dac.sv
// Scoreboard bench for parallel_to_serial_dac: three instances (dual/resend, dual/zero, single/resend)
// share stimulus; expected slot words are queued when samples are offered and checked per frame.
module tb_parallel_to_serial_dac;

  localparam logic [2:0] DUAL_CFG = 3'b011;
  localparam logic [2:0] UZ_CFG   = 3'b010;

  typedef struct packed {
    logic [15:0] word;
    logic        ur;
  } entry_t;

  logic        bclk = 1'b1;
  logic        reset_n;
  logic        lrclk;
  logic        in_valid;
  logic [15:0] in_data;
  logic [2:0]  out_s, ur_s, busy_s, rdy_s;

  entry_t      sb_q[$];
  logic [15:0] tb_last;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 bclk = ~bclk;

  parallel_to_serial_dac #(.WIDTH(16), .DUAL_CHANNEL(1'b1), .UNDERRUN_ZERO(1'b0)) u_d0 (
    .bclk(bclk), .reset_n(reset_n), .lrclk(lrclk), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_s[0]), .out_data(out_s[0]), .underrun(ur_s[0]), .busy(busy_s[0]));
  parallel_to_serial_dac #(.WIDTH(16), .DUAL_CHANNEL(1'b1), .UNDERRUN_ZERO(1'b1)) u_d1 (
    .bclk(bclk), .reset_n(reset_n), .lrclk(lrclk), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_s[1]), .out_data(out_s[1]), .underrun(ur_s[1]), .busy(busy_s[1]));
  parallel_to_serial_dac #(.WIDTH(16), .DUAL_CHANNEL(1'b0), .UNDERRUN_ZERO(1'b0)) u_d2 (
    .bclk(bclk), .reset_n(reset_n), .lrclk(lrclk), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_s[2]), .out_data(out_s[2]), .underrun(ur_s[2]), .busy(busy_s[2]));

  // One lrclk phase of len bclks; bits of the slot appear on posedges 2..17 after the lrclk change.
  task automatic phase(input logic level, input int len, input logic [47:0] exp_w, input logic [2:0] exp_ur,
                       input logic drain, input logic load_en, input logic [15:0] load_word, input int load_i);
    logic [15:0] got [3];
    logic [15:0] mask;
    lrclk = level;
    for (int d = 0; d < 3; d++) got[d] = 16'h0000;
    mask = 16'hFFFF;
    if (len < 17) mask = mask << (17 - len);
    for (int i = 1; i <= len; i++) begin
      @(posedge bclk); #1;
      for (int d = 0; d < 3; d++) begin
        if (i == 1 && drain) begin
          n_checks++;
          if (rdy_s[d] !== 1'b0) $display("FAIL ready_before_drain dut%0d got %b want 0", d, rdy_s[d]);
          else n_pass++;
        end
        if (i == 2 && drain) begin
          n_checks++;
          if (rdy_s[d] !== 1'b1) $display("FAIL ready_after_drain dut%0d got %b want 1", d, rdy_s[d]);
          else n_pass++;
        end
        if (i == 1 || i == 3) begin
          n_checks++;
          if (ur_s[d] !== 1'b0) $display("FAIL underrun_quiet dut%0d cyc%0d got %b want 0", d, i, ur_s[d]);
          else n_pass++;
        end
        if (i == 2) begin
          n_checks++;
          if (ur_s[d] !== exp_ur[d]) $display("FAIL underrun_pulse dut%0d got %b want %b", d, ur_s[d], exp_ur[d]);
          else n_pass++;
          n_checks++;
          if (busy_s[d] !== 1'b1) $display("FAIL busy_in_slot dut%0d got %b want 1", d, busy_s[d]);
          else n_pass++;
        end
        if (i >= 2 && i <= 17) got[d][17-i] = out_s[d];
        if (i == 18) begin
          n_checks++;
          if (out_s[d] !== 1'b0 || busy_s[d] !== 1'b0)
            $display("FAIL slot_end dut%0d got out=%b busy=%b want 0 0", d, out_s[d], busy_s[d]);
          else n_pass++;
        end
      end
      if (load_en && i == load_i) begin
        in_valid = 1'b1;
        in_data  = load_word;
        sb_q.push_back('{load_word, 1'b0});
      end
      if (load_en && i == load_i + 1) in_valid = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ((got[d] & mask) !== (exp_w[d*16 +: 16] & mask))
        $display("FAIL slot_word lvl%b dut%0d got %h want %h mask %h", level, d, got[d], exp_w[d*16 +: 16], mask);
      else n_pass++;
    end
  endtask

  // One frame: pop the expected sample, derive per-instance slot words, run low then high phase.
  task automatic frame(input int low_len, input logic load_en, input logic [15:0] load_word, input int load_i);
    entry_t      e;
    logic [47:0] exp_l, exp_r;
    logic [15:0] w;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
      e = '{16'h0000, 1'b1};
    end else begin
      e = sb_q.pop_front();
    end
    for (int d = 0; d < 3; d++) begin
      w = e.ur ? (UZ_CFG[d] ? 16'h0000 : tb_last) : e.word;
      exp_l[d*16 +: 16] = w;
      exp_r[d*16 +: 16] = DUAL_CFG[d] ? w : 16'h0000;
    end
    if (!e.ur) tb_last = e.word;
    phase(1'b0, low_len, exp_l, {3{e.ur}}, ~e.ur, load_en, load_word, load_i);
    phase(1'b1, 32, exp_r, 3'b000, 1'b0, 1'b0, 16'h0000, 0);
  endtask

  task automatic preload(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    sb_q.push_back('{w, 1'b0});
    @(posedge bclk); #1;
    in_valid = 1'b0;
    @(posedge bclk); #1;
  endtask

  task automatic starve();
    sb_q.push_back('{16'h0000, 1'b1});
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({out_s[d], ur_s[d], busy_s[d], rdy_s[d]} !== 4'b0001)
        $display("FAIL %s dut%0d got out/ur/busy/rdy=%b want 0001", tag, d, {out_s[d], ur_s[d], busy_s[d], rdy_s[d]});
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; lrclk = 1'b0; in_valid = 1'b0; in_data = 16'h0000; tb_last = 16'h0000;
    repeat (3) @(posedge bclk);
    #1;
    check_idle_outputs("reset_state");
    reset_n = 1'b1;
    @(posedge bclk); #1;
    phase(1'b1, 32, 48'h0, 3'b000, 1'b0, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_idle_frames();
    starve(); frame(32, 1'b0, 16'h0000, 0);
    starve(); frame(32, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_single_word();
    preload(16'hA5C3); frame(32, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_back_to_back();
    preload(16'h8001);
    frame(32, 1'b1, 16'h7FFE, 20);
    frame(32, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_underrun();
    preload(16'h1234); frame(32, 1'b0, 16'h0000, 0);
    starve();          frame(32, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_full_scale();
    preload(16'hFFFF); frame(32, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_short_slot();
    preload(16'h0F0F); frame(8, 1'b0, 16'h0000, 0);
    starve();          frame(32, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_reset_mid_slot();
    in_valid = 1'b1; in_data = 16'hC3C3;
    @(posedge bclk); #1;
    in_valid = 1'b0;
    @(posedge bclk); #1;
    lrclk = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge bclk); #1;
      if (i == 3) begin in_valid = 1'b1; in_data = 16'h5A5A; end
      if (i == 4) in_valid = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (busy_s[d] !== 1'b1 || rdy_s[d] !== 1'b0)
        $display("FAIL pre_reset_state dut%0d got busy=%b rdy=%b want 1 0", d, busy_s[d], rdy_s[d]);
      else n_pass++;
    end
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(posedge bclk); #1;
    reset_n = 1'b1;
    tb_last = 16'h0000;
    phase(1'b1, 32, 48'h0, 3'b000, 1'b0, 1'b0, 16'h0000, 0);
    starve(); frame(32, 1'b0, 16'h0000, 0);
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_full_scale();
    test_short_slot();
    test_reset_mid_slot();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/parallel_to_serial_dac.md
Name: parallel_to_serial_dac

Overview:
- Transmit-side counterpart of the ADC capture stage: takes 16-bit processed samples (echo/FIR output) via a valid/ready handshake and shifts them MSB-first onto the codec DAC serial line.
- Runs in the bclk domain and tracks lrclk, which is produced externally, using the same two-stage delay/edge-detect scheme as the capture side.
- A one-word holding register decouples the processing pipeline from frame timing.
- Underruns are flagged and handled deterministically.

Parameters:
- WIDTH, 16, sample width and bits shifted per channel slot.
- DUAL_CHANNEL, 1: 1 = the same sample is sent in both lrclk-low and lrclk-high slots; 0 = the lrclk-high slot sends zeros.
- UNDERRUN_ZERO, 0: on underrun, 0 = resend the last sample; 1 = send zero.

Ports:
- bclk, input, 1: bit clock. All flops update on the negedge of bclk.
- reset_n, input, 1: asynchronous active-low reset.
- lrclk, input, 1: left/right frame clock from the codec.
- in_data, input, WIDTH: sample from the processing stage.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: holding register is empty. Combinational, equal to ~hold_full.
- out_data, output, 1: serial data to the DAC. Registered.
- underrun, output, 1: one-cycle pulse when an lrclk-low slot starts with the holding register empty.
- busy, output, 1: high while shifting a slot.

Behaviour:
- Reset: lrclk_d1, lrclk_d2, hold_full, shift register, last_sample, bit_cnt and state all clear to 0 / IDLE. out_data=0, underrun=0, busy=0, in_ready=1.
- Edge detect:
  - lrclk_d1 <= lrclk and lrclk_d2 <= lrclk_d1 on each negedge.
  - start_l = lrclk_d2 & ~lrclk_d1, i.e. the falling edge of lrclk seen one bclk later.
  - start_r = ~lrclk_d2 & lrclk_d1.
- Handshake: a transfer occurs on a negedge where in_valid & in_ready. hold <= in_data and hold_full <= 1. No accept is possible while hold_full=1.
- FSM states: IDLE, SHIFT_L, SHIFT_R. bit_cnt counts down from WIDTH-1 to 0.
- On start_l (from any state):
  - If hold_full: shift register <= hold, last_sample <= hold, hold_full <= 0.
  - Else: underrun <= 1. Shift register <= last_sample, or 0 if UNDERRUN_ZERO=1; last_sample is unchanged in that case.
  - out_data <= MSB of the loaded word, bit_cnt <= WIDTH-1, state <= SHIFT_L.
- On start_r (from any state):
  - Shift register <= last_sample if DUAL_CHANNEL=1, else 0. This loads the post-update last_sample; in zero-underrun mode it sends 0.
  - out_data <= MSB, bit_cnt <= WIDTH-1, state <= SHIFT_R.
- Latency: the MSB is driven on the same negedge that start_x asserts (two negedges after the lrclk edge). Bit k follows on each subsequent negedge.
- In SHIFT_x with no start:
  - If bit_cnt != 0: shift left, out_data <= next bit, bit_cnt decrements.
  - If bit_cnt == 0: out_data <= 0, state <= IDLE.
  - Exactly WIDTH bits are driven per slot. Between slots out_data is 0.
- busy = (state != IDLE).
- Simultaneous start_l and accept with hold empty: the slot underruns and the new word lands in hold, used in the next frame.
- At start_l with hold full: hold drains. in_ready rises in the following cycle, never in the same cycle as the drain.
- A start pulse arriving mid-slot (short or glitched lrclk) aborts the current word and restarts for the new channel. No error flag is raised.
- If lrclk is high at reset release, the first event is start_r, which sends last_sample=0. Real data is only consumed on start_l.
- Reset mid-slot: out_data goes to 0 immediately, and any held word is discarded.

Test Plan:
- Reset with lrclk=0, then lrclk 32-high/32-low frames and in_valid held low → in_ready=1, out_data=0 in every slot, and underrun pulses once per lrclk falling edge.
- Preload 16'hA5C3 and wait for the lrclk fall → starting 2 negedges later, out_data = 1010010111000011 MSB-first in 16 bclks, then 0. The lrclk-high slot repeats A5C3 (DUAL_CHANNEL=1). in_ready returns to 1 the cycle after start_l.
- Load 16'h8001 then 16'h7FFE on successive frames → each slot carries its own word. The second word is accepted mid-frame and not used until the next start_l.
- Load 16'h1234, then starve one frame → underrun pulses and 1234 is resent (UNDERRUN_ZERO=0). With UNDERRUN_ZERO=1, the slot is all zeros.
- DUAL_CHANNEL=0, sample 16'hFFFF → lrclk-low slot is 16 ones; lrclk-high slot is 16 zeros.
- Shorten lrclk-low to 8 bclks mid-word, and separately assert reset_n=0 at bit 5 → the new slot restarts at MSB with no extra bits; reset forces out_data=0, busy=0, in_ready=1 asynchronously.
